// File: rtl/dcache_pkg.sv
// Shared types for the write-back data cache: controller state encoding and
// the RISC-V funct3 width/sign encodings used by loads and stores.
// No logic; imported by dcache_align and dcache_wb.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    GAP       = 2'd2,
    REFILL    = 2'd3
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dcache_align.sv
// Load extraction and store placement within one cache line (little-endian).
// Latency: purely combinational. Backpressure: none.
// Ports: line/offset/funct3/wdata in; rdata (extended load), byte_en and wline
// (store data shifted into its byte lanes) out.
module dcache_align
  import dcache_pkg::*;
#(
  parameter int OFFSET_WIDTH = 5
) (
  input  logic [(8<<OFFSET_WIDTH)-1:0] line,
  input  logic [OFFSET_WIDTH-1:0]      offset,
  input  logic [2:0]                   funct3,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata,
  output logic [(1<<OFFSET_WIDTH)-1:0] byte_en,
  output logic [(8<<OFFSET_WIDTH)-1:0] wline
);

  localparam int LINE_BITS  = 8 << OFFSET_WIDTH;
  localparam int LINE_BYTES = 1 << OFFSET_WIDTH;

  logic [1:0]              size;     // 0 = byte, 1 = half, 2 = word
  logic                    sign_ext;
  logic [OFFSET_WIDTH-1:0] aoff;     // offset aligned down to the access size
  logic [LINE_BITS-1:0]    line_sh;
  logic [LINE_BITS-1:0]    wide;
  logic [LINE_BYTES-1:0]   be_base;
  logic [31:0]             raw;

  always_comb begin
    size     = 2'd2;
    sign_ext = 1'b0;
    case (funct3)
      F3_B:    begin size = 2'd0; sign_ext = 1'b1; end
      F3_H:    begin size = 2'd1; sign_ext = 1'b1; end
      F3_BU:   size = 2'd0;
      F3_HU:   size = 2'd1;
      F3_W:    size = 2'd2;
      default: size = 2'd2;  // undefined encodings behave as a word access
    endcase
  end

  always_comb begin
    case (size)
      2'd0:    aoff = offset;
      2'd1:    aoff = {offset[OFFSET_WIDTH-1:1], 1'b0};
      default: aoff = {offset[OFFSET_WIDTH-1:2], 2'b00};
    endcase
  end

  // Load: bring the addressed bytes down to bit 0, then extend.
  always_comb begin
    line_sh = line >> {aoff, 3'b000};
    raw     = line_sh[31:0];
    case (size)
      2'd0:    rdata = sign_ext ? {{24{raw[7]}}, raw[7:0]}   : {24'd0, raw[7:0]};
      2'd1:    rdata = sign_ext ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
      default: rdata = raw;
    endcase
  end

  // Store: lane mask and data both shifted to the aligned offset.
  always_comb begin
    be_base    = '0;
    be_base[0] = 1'b1;
    if (size != 2'd0) be_base[1] = 1'b1;
    if (size == 2'd2) be_base[3:2] = 2'b11;
    byte_en    = be_base << aoff;
    wide       = '0;
    wide[31:0] = wdata;
    wline      = wide << {aoff, 3'b000};
  end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache between MEM stage and a
// line-wide memory port. Latency: hits complete in the lookup cycle; misses
// assert stall until refill (plus writeback and a gap cycle for dirty victims).
// Backpressure: stall holds the pipeline; memory side waits on mem_ready.
// Ports: clk/rst, MemRead/MemWrite/addr/WriteData/funct3 -> ReadData/stall,
// mem_req/mem_we/mem_addr/mem_wdata <- mem_rdata/mem_ready, hit/miss counters.
module dcache_wb
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          MemRead,
  input  logic                          MemWrite,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic [31:0]                   WriteData,
  input  logic [2:0]                    funct3,
  output logic [31:0]                   ReadData,
  output logic                          stall,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [(8<<OFFSET_WIDTH)-1:0]  mem_wdata,
  input  logic [(8<<OFFSET_WIDTH)-1:0]  mem_rdata,
  input  logic                          mem_ready,
  output logic [31:0]                   hit_count,
  output logic [31:0]                   miss_count
);

  localparam int TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int LINE_BITS  = 8 << OFFSET_WIDTH;
  localparam int LINE_BYTES = 1 << OFFSET_WIDTH;
  localparam int LINES      = 1 << INDEX_WIDTH;

  state_e state_q, state_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic [LINES-1:0]     dirty_q, dirty_d;
  logic [31:0]          hit_cnt_q, hit_cnt_d;
  logic [31:0]          miss_cnt_q, miss_cnt_d;
  logic                 retry_q, retry_d;  // marks the post-refill hit so it is not counted
  logic [TAG_WIDTH-1:0] tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  logic [TAG_WIDTH-1:0]    a_tag;
  logic [INDEX_WIDTH-1:0]  idx;
  logic [OFFSET_WIDTH-1:0] off;
  logic req, is_load, hit, fill_en, wb_done, store_en;
  logic [31:0]           ld_data;
  logic [LINE_BYTES-1:0] byte_en;
  logic [LINE_BITS-1:0]  wline, bit_mask, store_line;

  assign a_tag   = addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign idx     = addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign off     = addr[OFFSET_WIDTH-1:0];
  assign req     = MemRead | MemWrite;
  assign is_load = MemRead & ~MemWrite;
  assign hit     = valid_q[idx] && (tag_q[idx] == a_tag);

  assign fill_en  = (state_q == REFILL) && mem_ready;
  assign wb_done  = (state_q == WRITEBACK) && mem_ready;
  assign store_en = (state_q == IDLE) && MemWrite && hit;

  dcache_align #(.OFFSET_WIDTH(OFFSET_WIDTH)) u_align (
    .line    (data_q[idx]),
    .offset  (off),
    .funct3  (funct3),
    .wdata   (WriteData),
    .rdata   (ld_data),
    .byte_en (byte_en),
    .wline   (wline)
  );

  always_comb begin
    bit_mask = '0;
    for (int b = 0; b < LINE_BYTES; b++) bit_mask[b*8 +: 8] = {8{byte_en[b]}};
    store_line = (data_q[idx] & ~bit_mask) | (wline & bit_mask);
  end

  // State, status bits and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      retry_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      retry_q    <= retry_d;
    end
  end

  // Tag and data arrays carry no reset; valid_q gates their contents.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= a_tag;
      data_q[idx] <= mem_rdata;
    end else if (store_en) begin
      data_q[idx] <= store_line;
    end
  end

  // Next-state and bookkeeping.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    retry_d    = fill_en;
    case (state_q)
      IDLE: begin
        if (req && hit && !retry_q) hit_cnt_d = hit_cnt_q + 32'd1;
        if (req && !hit) begin
          miss_cnt_d = miss_cnt_q + 32'd1;
          state_d    = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : REFILL;
        end
        if (store_en) dirty_d[idx] = 1'b1;
      end
      WRITEBACK: if (mem_ready) begin
        dirty_d[idx] = 1'b0;
        state_d      = GAP;
      end
      GAP: state_d = REFILL;
      REFILL: if (mem_ready) begin
        valid_d[idx] = 1'b1;
        dirty_d[idx] = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    stall    = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = {a_tag, idx, {OFFSET_WIDTH{1'b0}}};
    ReadData = '0;
    case (state_q)
      IDLE: begin
        stall = req && !hit;
        if (is_load && hit) ReadData = ld_data;
      end
      WRITEBACK: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {tag_q[idx], idx, {OFFSET_WIDTH{1'b0}}};
      end
      GAP:     stall = 1'b1;
      REFILL:  begin stall = 1'b1; mem_req = 1'b1; end
      default: stall = 1'b1;
    endcase
    if (rst) stall = 1'b0;  // a lookup against cleared valid bits must not hold the pipe
  end

  assign mem_wdata  = data_q[idx];
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule
